uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one `uarttx` transmitter among NUM_REQ byte-stream requesters using round-robin arbitration.
- Each grant covers a burst of up to MAX_BURST bytes, or fewer if the requester marks a byte as last.
- Drives the transmitter's send/data/done handshake on the fast system clock.
- Adds a done-timeout so a stuck transmitter cannot lock the bus.
- Sits between the client logic and `uart_top`'s TX side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum bytes per grant (1..16).
- TIMEOUT_CYCLES, 4096, clk cycles allowed in SEND before the byte is abandoned.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; held high while data is pending.
- req_data  in  NUM_REQ*8  byte lane i at [8i+7:8i]; must be stable while req[i]=1.
- req_last  in  NUM_REQ  marks req_data[i] as the final byte of the message.
- req_ack  out  NUM_REQ  1-cycle pulse: byte from requester i was transmitted.
- grant  out  NUM_REQ  one-hot grant owner; all zero when idle.
- busy  out  1  high in any state except IDLE.
- uart_dintx  out  8  byte to the transmitter.
- uart_send  out  1  send request to the transmitter.
- uart_donetx  in  1  transmitter done flag; asynchronous to the handshake and may stay high for several clk cycles.
- timeout_err  out  1  1-cycle pulse when a byte times out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - grant, req_ack, uart_send, timeout_err, busy = 0; uart_dintx=8'h00.
  - rr_ptr=0, burst count=0, timeout counter=0, donetx sampling registers=0.
  - Reset asserted mid-transfer drops uart_send immediately. No ack is issued for the interrupted byte.
- uart_donetx handling: passed through a 2-flop synchroniser, then rising-edge detected (done_rise) and low-detected (done_low).
- IDLE:
  - If any req is high, go to ARB next cycle; otherwise stay.
- ARB (1 cycle):
  - Pick the first set req at or after rr_ptr, wrapping modulo NUM_REQ.
  - grant <= one-hot of the winner; burst count <= 0; go to LOAD.
  - If req dropped to all-zero meanwhile, return to IDLE.
- LOAD (1 cycle):
  - Latch uart_dintx <= the granted byte lane.
  - Latch last_flag <= req_last[g].
  - uart_send <= 1; clear the timeout counter; go to SEND.
- SEND:
  - Hold uart_send=1 and uart_dintx stable; the timeout counter increments each cycle.
  - On done_rise:
    - uart_send <= 0; pulse req_ack[g] for one cycle; burst count++.
    - Go to WAIT_LOW.
  - If the counter reaches TIMEOUT_CYCLES-1 without done_rise:
    - uart_send <= 0; pulse timeout_err; no ack.
    - Release the grant; go to RELEASE.
  - If done_rise and timeout land on the same cycle, done_rise wins.
- WAIT_LOW:
  - Wait for done_low, so the transmitter is back in idle before the next byte.
  - Then, if last_flag=0 AND burst count < MAX_BURST AND req[g]=1, go to LOAD (same requester).
  - Otherwise go to RELEASE.
- RELEASE (1 cycle):
  - grant <= 0; rr_ptr <= (g+1) mod NUM_REQ; go to IDLE.
- Requester obligations:
  - After seeing req_ack, the requester must present its next byte (or drop req) within the WAIT_LOW period.
  - req dropped during SEND does not abort the byte in flight.
- Fairness: no requester is granted twice while another requester is continuously requesting.
- Latency: from req rising in IDLE to uart_send high is 3 clk cycles (IDLE→ARB→LOAD→SEND).

Optional Feature:
- Macro: UART_ARB_STATS_EN.
- When defined:
  - Adds output byte_count [15:0]: total acked bytes, wrapping at 16'hFFFF→0.
  - Adds output timeout_count [7:0]: saturates at 8'hFF.
  - Both counters are cleared by rst.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Package uart_arb_pkg:
  - state enum type with IDLE, ARB, LOAD, SEND, WAIT_LOW, RELEASE.
  - Width localparams: ptr width = $clog2(NUM_REQ), burst width = $clog2(MAX_BURST+1), timeout width = $clog2(TIMEOUT_CYCLES).
- One sub-module, rr_pick: combinational round-robin selector taking req and rr_ptr, returning a one-hot winner and its index.
- Everything else stays in uart_tx_arbiter.

Test Plan:
- Single requester: req[0]=1 with 8'hA5, req_last=1, done model pulses → uart_dintx=8'hA5, exactly one req_ack[0], grant returns to 0, rr_ptr=1.
- Contention: req=4'b1111, each requester sends one byte with last=1 → grant order 0,1,2,3,0 with one ack each per cycle round.
- Burst cap: req[2] streams 6 bytes with last=0, MAX_BURST=4 → 4 acks, release, re-arbitration; with req[2] alone it is re-granted for the remaining 2 bytes.
- Timeout: done model never responds, TIMEOUT_CYCLES=16 → uart_send drops after 16 SEND cycles, timeout_err pulses once, no ack, next requester is granted.
- Reset mid-SEND: assert rst low while in SEND → uart_send, grant and busy are 0 immediately; after release, the idle bus accepts a new request normally.
- With UART_ARB_STATS_EN: 3 acked bytes and 1 timeout → byte_count=3, timeout_count=1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Optional statistics counters in the top level are enabled by UART_ARB_STATS_EN.
package uart_arb_pkg;

    // Arbiter FSM states; the encoding is exposed on the top-level dbg_state port.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARB      = 3'd1,
        LOAD     = 3'd2,
        SEND     = 3'd3,
        WAIT_LOW = 3'd4,
        RELEASE  = 3'd5
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_MAX_BURST      = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Width needed to index n values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NUM_REQ. Returns the winner one-hot and as an index.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = width_of(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0]   win_idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        found      = 1'b0;
        cand       = '0;
        win_idx    = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Each grant carries up to MAX_BURST bytes; a stuck transmitter is abandoned
// after TIMEOUT_CYCLES cycles in SEND.
// Define UART_ARB_STATS_EN to add the byte_count / timeout_count outputs.
//
// Handshakes:
//   Requester side: req[i] high means req_data/req_last lane i holds a valid
//   byte and must stay stable until req_ack[i] pulses for one cycle; the
//   requester then presents its next byte or drops req before done goes low.
//   Transmitter side: uart_send rises with uart_dintx stable and is held until
//   a synchronised rising edge of uart_donetx; the next byte is only offered
//   once uart_donetx is seen low again.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int MAX_BURST      = DEF_MAX_BURST,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [7:0]           uart_dintx,
    output logic                 uart_send,
    input  logic                 uart_donetx,
    output logic                 timeout_err,
`ifdef UART_ARB_STATS_EN
    output logic [15:0]          byte_count,
    output logic [7:0]           timeout_count,
`endif
    output logic [2:0]           dbg_state
);

    localparam int PTR_W   = width_of(NUM_REQ);
    localparam int BURST_W = width_of(MAX_BURST + 1);
    localparam int TO_W    = width_of(TIMEOUT_CYCLES);

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, g_idx, pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [BURST_W-1:0] burst_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               last_flag;
    logic               done_s1, done_s2, done_s3;
    logic               done_rise, done_low, timeout_hit, more_burst;
    logic               ack_evt, to_evt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req        (req),
        .ptr        (rr_ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx)
    );

    assign done_rise   = done_s2 & ~done_s3;
    assign done_low    = ~done_s2;
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign more_burst  = ~last_flag && (burst_cnt < BURST_W'(MAX_BURST)) && req[g_idx];
    // A done edge on the final timeout cycle still counts as delivered.
    assign ack_evt     = (state == SEND) && done_rise;
    assign to_evt      = (state == SEND) && !done_rise && timeout_hit;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    // Bring the transmitter's done flag into the clk domain; s3 holds the previous value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            done_s1 <= uart_donetx;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req != '0) state_nxt = ARB;
            ARB:      state_nxt = (req != '0) ? LOAD : IDLE;
            LOAD:     state_nxt = SEND;
            SEND: begin
                if (done_rise)        state_nxt = WAIT_LOW;
                else if (timeout_hit) state_nxt = RELEASE;
            end
            WAIT_LOW: if (done_low) state_nxt = more_burst ? LOAD : RELEASE;
            RELEASE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Grant ownership, byte latch, transmitter handshake and burst/timeout counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant       <= '0;
            g_idx       <= '0;
            rr_ptr      <= '0;
            burst_cnt   <= '0;
            to_cnt      <= '0;
            last_flag   <= 1'b0;
            uart_dintx  <= 8'h00;
            uart_send   <= 1'b0;
            req_ack     <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ack     <= '0;
            timeout_err <= 1'b0;
            case (state)
                ARB: begin
                    if (req != '0) begin
                        grant     <= pick_onehot;
                        g_idx     <= pick_idx;
                        burst_cnt <= '0;
                    end
                end
                LOAD: begin
                    uart_dintx <= req_data[{g_idx, 3'b000} +: 8];
                    last_flag  <= req_last[g_idx];
                    uart_send  <= 1'b1;
                    to_cnt     <= '0;
                end
                SEND: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (ack_evt) begin
                        uart_send      <= 1'b0;
                        req_ack[g_idx] <= 1'b1;
                        burst_cnt      <= burst_cnt + 1'b1;
                    end else if (to_evt) begin
                        uart_send   <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    grant  <= '0;
                    rr_ptr <= (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef UART_ARB_STATS_EN
    // Running totals: delivered bytes wrap, abandoned bytes saturate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_count    <= '0;
            timeout_count <= '0;
        end else begin
            if (ack_evt) begin
                byte_count <= byte_count + 16'd1;
            end
            if (to_evt && timeout_count != 8'hFF) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a transmitter done model,
// a queue-based arbitration reference and an event monitor.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int MAX_BURST      = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int EW             = 12;   // {is_ack, idx[2:0], data[7:0]}

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic [7:0]           uart_dintx;
  logic                 uart_send;
  logic                 uart_donetx;
  logic                 timeout_err;
  logic [2:0]           dbg_state;
`ifdef UART_ARB_STATS_EN
  logic [15:0]          byte_count;
  logic [7:0]           timeout_count;
`endif

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .MAX_BURST      (MAX_BURST),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ack       (req_ack),
    .grant         (grant),
    .busy          (busy),
    .uart_dintx    (uart_dintx),
    .uart_send     (uart_send),
    .uart_donetx   (uart_donetx),
    .timeout_err   (timeout_err),
`ifdef UART_ARB_STATS_EN
    .byte_count    (byte_count),
    .timeout_count (timeout_count),
`endif
    .dbg_state     (dbg_state)
  );

  // Pending bytes per requester {last, data}: staged, driven, and model copies.
  logic [8:0]    sq[NUM_REQ][$];
  logic [8:0]    rq[NUM_REQ][$];
  logic [8:0]    mq[NUM_REQ][$];
  logic [EW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int stuck_left   = 0;
  int model_ptr    = 0;
  int model_grants = 0;
  int obs_grants   = 0;
  int exp_acks     = 0;
  int exp_tos      = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: round robin over non-empty queues; a grant ends on a last byte,
  // after MAX_BURST bytes, when the queue runs dry, or on an abandoned byte.
  task automatic run_model(input int stuck_in);
    int stuck, w, c, sent;
    bit fin, any;
    logic [8:0] e;
    stuck = stuck_in;
    any = 1'b1;
    while (any) begin
      w = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (model_ptr + k) % NUM_REQ;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w < 0) begin
        any = 1'b0;
      end else begin
        model_grants++;
        sent = 0;
        fin = 1'b0;
        while (!fin) begin
          if (stuck > 0) begin
            stuck--;
            e = mq[w][0];
            exp_q.push_back({1'b0, 3'(w), e[7:0]});
            exp_tos++;
            fin = 1'b1;
          end else begin
            e = mq[w].pop_front();
            exp_q.push_back({1'b1, 3'(w), e[7:0]});
            exp_acks++;
            sent++;
            if (e[8] || sent == MAX_BURST || mq[w].size() == 0) fin = 1'b1;
          end
        end
        model_ptr = (w + 1) % NUM_REQ;
      end
    end
  endtask

  // Driver: predict, release the staged bytes to the requesters, wait for the bus to drain.
  task automatic run_scenario(input string name, input int stuck, input bit meas_lat);
    int n, waited;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = sq[i];
    model_grants = 0;
    run_model(stuck);
    @(posedge clk); #1;
    obs_grants = 0;
    stuck_left = stuck;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i] = sq[i];
      sq[i].delete();
    end
    if (meas_lat) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!uart_send && n < 20);
      check({name, "_latency"}, 32'(n - 1), 32'd3);
    end
    waited = 0;
    while ((exp_q.size() != 0 || busy || pending()) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_drained"}, 32'(waited >= 5000), 32'd0);
    check({name, "_grants"}, 32'(obs_grants), 32'(model_grants));
  endtask

  // Requesters: pop on ack, present the front byte while anything is pending.
  initial begin
    req = '0;
    req_data = '0;
    req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req[i] = 1'b0;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter: answer each send after a random delay with a multi-cycle done,
  // or stay silent for the next stuck_left sends.
  initial begin
    uart_donetx = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && uart_send) begin
        if (stuck_left > 0) begin
          stuck_left--;
        end else begin
          repeat ($urandom_range(1, 5)) @(negedge clk);
          uart_donetx = 1'b1;
          repeat ($urandom_range(2, 5)) @(negedge clk);
          uart_donetx = 1'b0;
        end
        for (int k = 0; k < 200 && uart_send; k++) @(negedge clk);
      end
    end
  end

  // Monitor: every ack / timeout pulse is compared with the next expected event.
  initial begin
    int run, last_run, idx;
    logic [NUM_REQ-1:0] prev_grant;
    logic [EW-1:0] obs, exp;
    run = 0;
    last_run = 0;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        run = 0;
        prev_grant = '0;
      end else begin
        if (uart_send) run++;
        else begin
          if (run > 0) last_run = run;
          run = 0;
        end
        if (grant != '0 && prev_grant == '0) obs_grants++;
        prev_grant = grant;
        if (req_ack != '0 || timeout_err) begin
          idx = 0;
          for (int i = 0; i < NUM_REQ; i++) if (req_ack[i] || (timeout_err && grant[i])) idx = i;
          obs = {(req_ack != '0), 3'(idx), uart_dintx};
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got 0x%0h expected none", obs);
          end else begin
            exp = exp_q.pop_front();
            check("event", 32'(obs), 32'(exp));
            check("grant_at_event", 32'(grant), 32'd1 << exp[10:8]);
            if (exp[11]) check("ack_onehot", 32'($countones(req_ack)), 32'd1);
            else         check("timeout_len", 32'(last_run), 32'(TIMEOUT_CYCLES));
          end
        end
      end
    end
  end

  // Main sequence.
  initial begin
    int cnt;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_send", 32'(uart_send), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dintx", 32'(uart_dintx), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester, single byte
    sq[0].push_back({1'b1, 8'hA5});
    run_scenario("single", 0, 1'b1);
    check("single_idle_grant", 32'(grant), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // All requesters contending, one-byte messages
    for (int i = 0; i < NUM_REQ; i++)
      for (int b = 0; b < 2; b++) sq[i].push_back({1'b1, 8'(16 * i + b)});
    run_scenario("contention", 0, 1'b0);

    // Burst cap with a competitor, then alone
    for (int b = 0; b < 6; b++) sq[2].push_back({1'b0, 8'(8'hC0 + b)});
    sq[3].push_back({1'b1, 8'h3E});
    run_scenario("burst_shared", 0, 1'b0);
    for (int b = 0; b < 6; b++) sq[2].push_back({1'b0, 8'(8'hD0 + b)});
    run_scenario("burst_solo", 0, 1'b0);

    // Silent transmitter on the first byte
    sq[1].push_back({1'b1, 8'h51});
    sq[2].push_back({1'b1, 8'h52});
    run_scenario("timeout", 1, 1'b0);

    // Random traffic
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          cnt = $urandom_range(1, 7);
          for (int b = 0; b < cnt; b++)
            sq[i].push_back({1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255))});
        end
      end
      if (sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size() == 0)
        sq[$urandom_range(0, NUM_REQ - 1)].push_back({1'b1, 8'h77});
      run_scenario("random", int'($urandom_range(0, 1)), 1'b0);
    end

    // Reset while a byte is in SEND
    stuck_left = 1;
    @(posedge clk); #1;
    rq[0].push_back({1'b1, 8'h3C});
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!uart_send && cnt < 20);
    check("pre_reset_send", 32'(uart_send), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_send", 32'(uart_send), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    stuck_left = 0;
    model_ptr = 0;
    exp_acks = 0;
    exp_tos = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Traffic after reset: three delivered bytes and one abandoned attempt
    sq[0].push_back({1'b0, 8'h61});
    sq[0].push_back({1'b1, 8'h62});
    sq[1].push_back({1'b1, 8'h71});
    run_scenario("post_reset", 1, 1'b1);

`ifdef UART_ARB_STATS_EN
    check("byte_count", 32'(byte_count), 32'(exp_acks));
    check("timeout_count", 32'(timeout_count), 32'(exp_tos));
`endif
    $display("model totals since last reset: %0d bytes, %0d timeouts", exp_acks, exp_tos);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time limit
  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test, required completion within 80000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
